cdb_request_buffer: RTL and testbench
=====================================

// Module: cdb_request_buffer
//
// PURPOSE
// - Requester-side partner of the CDB arbiter: one instance per functional unit (FU).
// - Queues completed FU results in a small circular FIFO.
// - Presents the oldest result as one CDB request lane (valid plus payload).
// - Pops that result when the arbiter returns the matching gnt bit.
// - Back-pressures the FU when full; a squash flushes everything queued.
//
// PARAMETERS
// - DEPTH   4   FIFO entries; power of two, >= 2; pointer width $clog2(DEPTH).
//
// PORTS
// - clock              in   1              system clock, all state on posedge
// - reset              in   1              synchronous, active-high
// - squash             in   1              ROB mispredict flush; synchronous clear
// - fu_valid           in   1              FU has a completed result this cycle
// - fu_data            in   `XLEN          result value
// - fu_prf_idx         in   $clog2(`PRF)   destination physical register
// - fu_rob_idx         in   $clog2(`ROB)   ROB entry of the instruction
// - fu_direction       in   1              branch taken
// - fu_target          in   `XLEN          branch target
// - fu_reg_write       in   1              result writes the PRF
// - fu_ready           out  1              buffer can accept a result this cycle
// - gnt                in   1              arbiter grant for this lane (one bit of its gnt)
// - CDB_valid_out      out  1              request valid; drives one CDB_valid_in bit
// - CDB_Data_out       out  `XLEN          head payload; same for all CDB_*_out below
// - CDB_PRF_idx_out    out  $clog2(`PRF)
// - CDB_ROB_idx_out    out  $clog2(`ROB)
// - CDB_direction_out  out  1
// - CDB_target_out     out  `XLEN
// - CDB_reg_write_out  out  1
//
// BEHAVIOUR
// - State
//   - head, tail: $clog2(DEPTH) bits, wrap modulo DEPTH.
//   - count: $clog2(DEPTH)+1 bits.
//   - Payload storage: DEPTH entries.
// - Reset or squash (reset dominates; both behave identically)
//   - Next cycle: head = tail = count = 0.
//   - A push or pop in the same cycle is discarded.
//   - Payload storage is not cleared.
// - Ready and handshakes
//   - fu_ready = (count != DEPTH); comes only from registered state, with no
//     combinational path from gnt.
//   - Push = fu_valid && fu_ready && !squash: writes entry[tail], tail += 1.
//   - fu_valid while fu_ready == 0: result is dropped; the FU must hold it
//     and retry.
//   - Pop = CDB_valid_out && gnt: head += 1.
//   - gnt while CDB_valid_out == 0: ignored.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - Full means fu_ready = 0, so there is no push that cycle even if a pop
//     occurs; this removes any ready-to-gnt path.
// - Output when count > 0
//   - CDB_valid_out = !squash; CDB_*_out = entry[head].
// - Output when count == 0, without CDB_BYPASS_EN
//   - CDB_valid_out = 0, all CDB_*_out = 0.
// - Latency
//   - Without bypass: a result pushed in cycle N is first requested in N+1.
//   - Request persists, payload stable, until the cycle gnt is seen.
// - Reset values
//   - fu_ready = 1, CDB_valid_out = 0, all payload outputs = 0.
// - Ordering
//   - Strict FIFO; results leave in push order.
//
// CONFIGURATION
// - Macro: CDB_BYPASS_EN.
// - Defined: when count == 0 and fu_valid && !squash, the buffer presents the
//   FU result directly.
//   - CDB_valid_out = 1 and CDB_*_out = fu_* in the same cycle (zero latency).
//   - gnt in that cycle consumes it: nothing is written, tail is unchanged.
//   - No gnt: the result is pushed as normal.
//   - The FU must not derive fu_valid from gnt (no loop).
// - Undefined: no combinational path from fu_* to CDB_*_out; latency is
//   1 cycle minimum.
//
// TESTING
// - Reset: hold reset 2 cycles with fu_valid = 1
//   -> CDB_valid_out = 0, fu_ready = 1, count 0 after release.
// - Single result: push rob_idx=5, data=32'hDEADBEEF, gnt = 0 for 3 cycles, then 1
//   -> valid held with stable payload;
//   -> valid drops the cycle after gnt (bypass: valid in the push cycle).
// - Fill and order: push rob 1,2,3,4 with DEPTH=4, no gnt
//   -> fu_ready = 0 after the 4th push; a 5th fu_valid is dropped;
//   -> with gnt = 1 continuously, results leave in order 1,2,3,4.
// - Simultaneous push and pop at count=2: push rob 9 with gnt = 1
//   -> count stays 2, head item popped, rob 9 emerges after the two older items.
// - Squash: count=3 plus a push in the squash cycle
//   -> CDB_valid_out = 0 that cycle;
//   -> next cycle count 0, fu_ready = 1, pushed item absent.
// - Wrap-around: 10 push/pop pairs with DEPTH=4
//   -> pointers wrap, no lost or duplicated rob_idx, payload matches a
//      scoreboard model.

Source files
------------

// File: rtl/cdb_request_buffer.sv
// Per-FU result FIFO that raises one CDB request lane; 1-cycle push-to-request latency (0 with CDB_BYPASS_EN).
// fu_ready drops only when full (registered, no gnt path); squash/reset empty the queue next cycle.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef ROB
`define ROB 32
`endif

module cdb_request_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic                      fu_valid,
  input  logic [`XLEN-1:0]          fu_data,
  input  logic [$clog2(`PRF)-1:0]   fu_prf_idx,
  input  logic [$clog2(`ROB)-1:0]   fu_rob_idx,
  input  logic                      fu_direction,
  input  logic [`XLEN-1:0]          fu_target,
  input  logic                      fu_reg_write,
  output logic                      fu_ready,
  input  logic                      gnt,
  output logic                      CDB_valid_out,
  output logic [`XLEN-1:0]          CDB_Data_out,
  output logic [$clog2(`PRF)-1:0]   CDB_PRF_idx_out,
  output logic [$clog2(`ROB)-1:0]   CDB_ROB_idx_out,
  output logic                      CDB_direction_out,
  output logic [`XLEN-1:0]          CDB_target_out,
  output logic                      CDB_reg_write_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [`XLEN-1:0]        data;
    logic [$clog2(`PRF)-1:0] prf_idx;
    logic [$clog2(`ROB)-1:0] rob_idx;
    logic                    direction;
    logic [`XLEN-1:0]        target;
    logic                    reg_write;
  } cdb_pkt_t;

  cdb_pkt_t        mem [DEPTH];
  cdb_pkt_t        fu_pkt;
  cdb_pkt_t        out_pkt;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            bypass_take;

  assign fu_pkt = '{data: fu_data, prf_idx: fu_prf_idx, rob_idx: fu_rob_idx,
                    direction: fu_direction, target: fu_target, reg_write: fu_reg_write};

  assign fu_ready = (count != FULL);

  always_comb begin
    out_pkt       = '0;
    CDB_valid_out = 1'b0;
    bypass_take   = 1'b0;
    if (count != '0) begin
      CDB_valid_out = !squash && !reset;
      out_pkt       = mem[head];
    end
`ifdef CDB_BYPASS_EN
    // Empty queue: forward the FU result straight onto the lane; a grant consumes it in place.
    else if (fu_valid && !squash && !reset) begin
      CDB_valid_out = 1'b1;
      out_pkt       = fu_pkt;
      bypass_take   = gnt;
    end
`endif
  end

  assign push = fu_valid && fu_ready && !squash && !reset && !bypass_take;
  assign pop  = CDB_valid_out && gnt && (count != '0);

  assign CDB_Data_out      = out_pkt.data;
  assign CDB_PRF_idx_out   = out_pkt.prf_idx;
  assign CDB_ROB_idx_out   = out_pkt.rob_idx;
  assign CDB_direction_out = out_pkt.direction;
  assign CDB_target_out    = out_pkt.target;
  assign CDB_reg_write_out = out_pkt.reg_write;

  always_ff @(posedge clock) begin
    if (reset || squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= fu_pkt;
  end

endmodule

// File: tb/tb_cdb_request_buffer.sv
// Randomized and directed bench for cdb_request_buffer against a queue-based reference model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef ROB
`define ROB 32
`endif

module tb_cdb_request_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [`XLEN-1:0]        data;
    logic [$clog2(`PRF)-1:0] prf_idx;
    logic [$clog2(`ROB)-1:0] rob_idx;
    logic                    direction;
    logic [`XLEN-1:0]        target;
    logic                    reg_write;
  } pkt_t;

  logic clock = 1'b0;
  logic reset, squash, fu_valid, gnt;
  pkt_t cur_fu;
  logic fu_ready, CDB_valid_out;
  logic [`XLEN-1:0]        CDB_Data_out, CDB_target_out;
  logic [$clog2(`PRF)-1:0] CDB_PRF_idx_out;
  logic [$clog2(`ROB)-1:0] CDB_ROB_idx_out;
  logic CDB_direction_out, CDB_reg_write_out;

  int   checks = 0;
  int   errors = 0;
  pkt_t model_q[$];
  logic [$clog2(`ROB)-1:0] last_rob;
  logic last_vld;

  always #5 clock = ~clock;

  cdb_request_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_data(cur_fu.data), .fu_prf_idx(cur_fu.prf_idx),
    .fu_rob_idx(cur_fu.rob_idx), .fu_direction(cur_fu.direction),
    .fu_target(cur_fu.target), .fu_reg_write(cur_fu.reg_write),
    .fu_ready(fu_ready), .gnt(gnt), .CDB_valid_out(CDB_valid_out),
    .CDB_Data_out(CDB_Data_out), .CDB_PRF_idx_out(CDB_PRF_idx_out),
    .CDB_ROB_idx_out(CDB_ROB_idx_out), .CDB_direction_out(CDB_direction_out),
    .CDB_target_out(CDB_target_out), .CDB_reg_write_out(CDB_reg_write_out)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fu(input logic vld, input int rob);
    fu_valid          = vld;
    cur_fu.data       = $urandom;
    cur_fu.prf_idx    = $urandom_range(0, `PRF - 1);
    cur_fu.rob_idx    = rob[$clog2(`ROB)-1:0];
    cur_fu.direction  = $urandom_range(0, 1);
    cur_fu.target     = $urandom;
    cur_fu.reg_write  = $urandom_range(0, 1);
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances the model.
  task automatic tick();
    bit   exp_vld = 1'b0;
    bit   exp_rdy = 1'b1;
    bit   bypass  = 1'b0;
    pkt_t exp_p   = '0;
    pkt_t obs_p;
    #1;
    obs_p = '{data: CDB_Data_out, prf_idx: CDB_PRF_idx_out, rob_idx: CDB_ROB_idx_out,
              direction: CDB_direction_out, target: CDB_target_out, reg_write: CDB_reg_write_out};
    last_rob = CDB_ROB_idx_out;
    last_vld = CDB_valid_out;
    if (!reset) begin
      exp_rdy = (model_q.size() != DEPTH);
      if (model_q.size() > 0) begin
        exp_vld = !squash;
        exp_p   = model_q[0];
      end
`ifdef CDB_BYPASS_EN
      else if (fu_valid && !squash) begin
        bypass  = 1'b1;
        exp_vld = 1'b1;
        exp_p   = cur_fu;
      end
`endif
      chk("fu_ready", fu_ready, exp_rdy);
      chk("cdb_valid", CDB_valid_out, exp_vld);
      chk("cdb_payload", obs_p, exp_p);
    end
    @(posedge clock);
    if (reset || squash) begin
      model_q.delete();
    end else begin
      if (exp_vld && gnt && !bypass) void'(model_q.pop_front());
      if (fu_valid && exp_rdy && !(bypass && gnt)) model_q.push_back(cur_fu);
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; gnt = 1'b0;
    set_fu(1'b1, 0);
    @(negedge clock);

    // Reset held two cycles with a valid FU result present.
    tick(); tick();
    reset = 1'b0; fu_valid = 1'b0;
    tick();
    chk("reset_valid", last_vld, 1'b0);

    // Single result held until granted.
    set_fu(1'b1, 5);
    cur_fu.data = 32'hDEADBEEF;
    tick();
    fu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_rob", last_rob, 5);
    end
    gnt = 1'b1; tick();
    gnt = 1'b0; tick();
    chk("single_drop", last_vld, 1'b0);

    // Fill to DEPTH, drop the extra push, drain in order.
    for (int i = 1; i <= 4; i++) begin set_fu(1'b1, i); tick(); end
    set_fu(1'b1, 6);
    tick();
    chk("full_ready", fu_ready, 1'b0);
    fu_valid = 1'b0; gnt = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("fill_order", last_rob, i);
    end
    tick();
    chk("fill_empty", last_vld, 1'b0);
    gnt = 1'b0;

    // Push and pop together at count 2.
    set_fu(1'b1, 7); tick();
    set_fu(1'b1, 8); tick();
    set_fu(1'b1, 9); gnt = 1'b1; tick();
    chk("simul_count", model_q.size(), 2);
    fu_valid = 1'b0;
    tick(); chk("simul_ord8", last_rob, 8);
    tick(); chk("simul_ord9", last_rob, 9);
    tick();
    gnt = 1'b0;

    // Squash with three queued and a push in the same cycle.
    for (int i = 10; i < 13; i++) begin set_fu(1'b1, i); tick(); end
    set_fu(1'b1, 13); squash = 1'b1; tick();
    chk("squash_valid", last_vld, 1'b0);
    squash = 1'b0; fu_valid = 1'b0; tick();
    chk("squash_after", last_vld, 1'b0);

    // Ten push/pop pairs wrap both pointers.
    set_fu(1'b1, 20); tick();
    gnt = 1'b1;
    for (int i = 21; i < 31; i++) begin set_fu(1'b1, i); tick(); end
    fu_valid = 1'b0; tick(); tick();
    gnt = 1'b0;

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      set_fu($urandom_range(0, 1), $urandom_range(0, `ROB - 1));
      gnt    = ($urandom_range(0, 2) != 0);
      squash = ($urandom_range(0, 29) == 0);
      tick();
    end
    squash = 1'b0; fu_valid = 1'b0; gnt = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
